uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one uart_tx.
// A single FSM latches the winner's byte, issues send_signal, reissues it
// if the transmitter never reports busy, and reports completion per owner.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_LEN     = 8,
  parameter int RETRY_CYCLES = 4,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic [ID_W-1:0]              active_id,
  output logic                         busy,
  output logic                         send_signal,
  output logic [DATA_LEN-1:0]          data,
  input  logic                         tx_busy,
  input  logic                         tx_done
);

  // Retry counter must be able to hold RETRY_CYCLES-1.
  localparam int RC_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RELEASE   = 3'd4
  } state_e;

  state_e              state_q;
  logic [ID_W-1:0]     last_q;
  logic [ID_W-1:0]     active_id_q;
  logic [RC_W-1:0]     retry_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                busy_q;
  logic                send_q;
  logic [DATA_LEN-1:0] data_q;

  logic [ID_W-1:0]     win_id_d;
  logic [DATA_LEN-1:0] win_data_d;

  // Round-robin search: start just after the last completed owner and wrap.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    l);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] cand;
    logic            found;
    logic            take;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand  = ID_W'((int'(l) + i) % NUM_REQ);
      take  = ~found & r[cand];
      pick  = take ? cand : pick;
      found = found | r[cand];
    end
    return pick;
  endfunction

  // Requester index to one-hot pulse vector.
  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  // Candidate winner and its byte; only consumed when the FSM is in IDLE.
  always_comb begin
    win_id_d   = rr_pick(req, last_q);
    win_data_d = req_data[win_id_d*DATA_LEN +: DATA_LEN];
  end

  // Arbitration FSM with every output produced directly from a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_q      <= ID_W'(NUM_REQ - 1);
      active_id_q <= '0;
      retry_q     <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      send_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      // Pulse outputs are low unless a transition below raises them.
      grant_q <= '0;
      done_q  <= '0;
      send_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            active_id_q <= win_id_d;
            data_q      <= win_data_d;
            grant_q     <= id_onehot(win_id_d);
            send_q      <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          retry_q <= '0;
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (tx_done) begin
            done_q  <= id_onehot(active_id_q);
            last_q  <= active_id_q;
            state_q <= S_RELEASE;
          end else if (retry_q == RC_W'(RETRY_CYCLES - 1)) begin
            // Counting this cycle the wait has lasted RETRY_CYCLES cycles,
            // so the reissued strobe lands RETRY_CYCLES+1 after the last one.
            send_q  <= 1'b1;
            state_q <= S_ISSUE;
          end else begin
            retry_q <= retry_q + RC_W'(1);
            state_q <= S_WAIT_BUSY;
          end
        end
        S_WAIT_DONE: begin
          if (tx_done) begin
            done_q  <= id_onehot(active_id_q);
            last_q  <= active_id_q;
            state_q <= S_RELEASE;
          end else begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_RELEASE: begin
          // One idle cycle so uart_tx leaves its post-stop state first.
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign active_id   = active_id_q;
  assign busy        = busy_q;
  assign send_signal = send_q;
  assign data        = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx
// (CLKS_PER_BIT=4) and a serial-line receiver feeding a scoreboard.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DL = 8;
  localparam int RC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [NR*DL-1:0] req_data;
  logic [NR-1:0] grant;
  logic [NR-1:0] done;
  logic [1:0]    active_id;
  logic          busy;
  logic          send_signal;
  logic [DL-1:0] data;
  logic          tx_busy;
  logic          tx_done;

  // uart_tx model state
  logic       m_en;
  logic       m_busy;
  logic       m_done;
  logic [9:0] m_sh;
  logic [3:0] m_bit;
  logic [1:0] m_clk;
  logic       tx_line;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int grant_cnt = 0;
  int done_cnt = 0;
  logic prev_tx_done = 1'b0;

  int         exp_grant[$];
  logic [7:0] exp_gdata[$];
  int         exp_done[$];
  logic [7:0] exp_ser[$];
  int         send_times[$];

  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] bytes_a [NR];

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_LEN(DL), .RETRY_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .active_id(active_id), .busy(busy),
    .send_signal(send_signal), .data(data),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  assign tx_busy = m_en & m_busy;
  assign tx_done = m_en & m_done;
  assign tx_line = m_busy ? m_sh[0] : 1'b1;

  // Behavioural uart_tx: start bit, 8 data bits LSB first, stop bit, 4 clocks each.
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_sh   <= 10'h3FF;
      m_bit  <= 4'd0;
      m_clk  <= 2'd0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (m_en && send_signal) begin
          m_busy <= 1'b1;
          m_sh   <= {1'b1, data, 1'b0};
          m_bit  <= 4'd0;
          m_clk  <= 2'd0;
        end
      end else if (m_clk == 2'd3) begin
        m_clk <= 2'd0;
        if (m_bit == 4'd9) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_bit <= m_bit + 4'd1;
          m_sh  <= {1'b1, m_sh[9:1]};
        end
      end else begin
        m_clk <= m_clk + 2'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int id);
    logic [NR-1:0] r;
    r = 4'b0001 << id;
    return r;
  endfunction

  // Advance one cycle; sample outputs on the falling edge and run the scoreboard.
  task automatic tick();
    int id;
    @(negedge clk);
    cyc++;
    if (grant !== 4'b0000) begin
      grant_cnt++;
      if (exp_grant.size() == 0) begin
        check("grant_unexpected", 32'(grant), 32'd0);
      end else begin
        id = exp_grant.pop_front();
        check("grant_order", 32'(grant), 32'(oh(id)));
        check("grant_data", 32'(data), 32'(exp_gdata.pop_front()));
        check("grant_active_id", 32'(active_id), 32'(id));
      end
    end
    if (done !== 4'b0000) begin
      done_cnt++;
      check("done_after_tx_done", 32'(prev_tx_done), 32'd1);
      if (exp_done.size() == 0) begin
        check("done_unexpected", 32'(done), 32'd0);
      end else begin
        id = exp_done.pop_front();
        check("done_id", 32'(done), 32'(oh(id)));
      end
    end
    if (send_signal === 1'b1) send_times.push_back(cyc);
    // Serial receiver: mid-bit sampling relative to the start-bit edge.
    if (reset === 1'b1) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx_line === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_byte = {tx_line, rx_byte[7:1]};
      if (rx_cnt == 38) begin
        rx_act = 1'b0;
        check("stop_bit", 32'(tx_line), 32'd1);
        if (exp_ser.size() == 0) check("frame_unexpected", 32'(rx_byte), 32'hFFFF_FFFF);
        else check("serial_byte", 32'(rx_byte), 32'(exp_ser.pop_front()));
      end
    end
    prev_tx_done = tx_done;
    #1;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_data();
    req_data = {bytes_a[3], bytes_a[2], bytes_a[1], bytes_a[0]};
  endtask

  task automatic expect_xfer(input int id, input bit completes);
    exp_grant.push_back(id);
    exp_gdata.push_back(bytes_a[id]);
    if (completes) begin
      exp_done.push_back(id);
      exp_ser.push_back(bytes_a[id]);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_grant"}, 32'(grant), 32'd0);
    check({p, "_done"}, 32'(done), 32'd0);
    check({p, "_send"}, 32'(send_signal), 32'd0);
    check({p, "_busy"}, 32'(busy), 32'd0);
    check({p, "_active_id"}, 32'(active_id), 32'd0);
    check({p, "_data"}, 32'(data), 32'd0);
  endtask

  initial begin
    int d0;
    int g0;
    reset = 1'b1;
    req   = 4'b0000;
    m_en  = 1'b1;
    for (int i = 0; i < NR; i++) bytes_a[i] = 8'h00;
    set_data();
    tick();
    tick();
    check_zero("reset_state");
    reset = 1'b0;

    // Single request: latency 1 grant, one-cycle send, done after tx_done.
    bytes_a[0] = 8'h55;
    set_data();
    req = 4'b0001;
    expect_xfer(0, 1'b1);
    d0 = done_cnt;
    tick();
    check("single_grant", 32'(grant), 32'h1);
    check("single_send", 32'(send_signal), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    check("single_data", 32'(data), 32'h55);
    req = 4'b0000;
    tick();
    check("issue_one_cycle_send", 32'(send_signal), 32'd0);
    check("grant_one_cycle", 32'(grant), 32'd0);
    wait_done("single_wait_done", d0 + 1, 100);
    check("single_done", 32'(done), 32'h1);
    check("single_busy_release", 32'(busy), 32'd1);
    tick();
    check("single_busy_idle", 32'(busy), 32'd0);
    check("single_done_cleared", 32'(done), 32'd0);

    // All requesting: grant order 0,1,2,3,0.
    do_reset();
    bytes_a[0] = 8'h10; bytes_a[1] = 8'h21; bytes_a[2] = 8'h32; bytes_a[3] = 8'h43;
    set_data();
    expect_xfer(0, 1'b1); expect_xfer(1, 1'b1); expect_xfer(2, 1'b1);
    expect_xfer(3, 1'b1); expect_xfer(0, 1'b1);
    d0 = done_cnt;
    req = 4'b1111;
    wait_done("all_wait_done", d0 + 5, 400);
    req = 4'b0000;

    // No starvation: req[0] and req[2] held -> 0,2,0,2.
    do_reset();
    bytes_a[0] = 8'hE0; bytes_a[2] = 8'hE2;
    set_data();
    expect_xfer(0, 1'b1); expect_xfer(2, 1'b1);
    expect_xfer(0, 1'b1); expect_xfer(2, 1'b1);
    d0 = done_cnt;
    req = 4'b0101;
    wait_done("starve_wait_done", d0 + 4, 400);
    req = 4'b0000;

    // Stalled transmitter: send every 5 cycles, one grant, no done.
    do_reset();
    m_en = 1'b0;
    bytes_a[1] = 8'h5A;
    set_data();
    expect_xfer(1, 1'b0);
    d0 = done_cnt;
    g0 = grant_cnt;
    send_times.delete();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    repeat (20) tick();
    check("stall_send_count_ge4", 32'(send_times.size() >= 4), 32'd1);
    if (send_times.size() >= 4) begin
      for (int i = 1; i < 4; i++) check("stall_send_period", 32'(send_times[i] - send_times[i-1]), 32'd5);
    end
    check("stall_single_grant", 32'(grant_cnt - g0), 32'd1);
    check("stall_no_done", 32'(done_cnt), 32'(d0));
    exp_done.push_back(1);
    exp_ser.push_back(8'h5A);
    m_en = 1'b1;
    wait_done("stall_recover_done", d0 + 1, 120);

    // Reset mid-transfer: outputs clear, no done, requester 0 wins next.
    do_reset();
    bytes_a[2] = 8'h77;
    set_data();
    expect_xfer(2, 1'b0);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    repeat (10) tick();
    check("midxfer_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check_zero("midxfer_reset");
    reset = 1'b0;
    d0 = done_cnt;
    repeat (50) tick();
    check("midxfer_no_done", 32'(done_cnt), 32'(d0));
    bytes_a[0] = 8'hC1; bytes_a[3] = 8'hC4;
    set_data();
    expect_xfer(0, 1'b1);
    req = 4'b1001;
    tick();
    check("post_reset_prio0", 32'(grant), 32'h1);
    req = 4'b0000;
    wait_done("post_reset_done", d0 + 1, 100);

    // Data hold: requester changes its byte right after grant.
    do_reset();
    bytes_a[1] = 8'hA3;
    set_data();
    expect_xfer(1, 1'b1);
    d0 = done_cnt;
    req = 4'b0010;
    tick();
    check("hold_grant", 32'(grant), 32'h2);
    bytes_a[1] = 8'h00;
    set_data();
    req = 4'b0000;
    tick();
    check("hold_data_next", 32'(data), 32'hA3);
    wait_done("hold_done", d0 + 1, 100);
    check("hold_data_end", 32'(data), 32'hA3);

    repeat (5) tick();
    check("sb_grant_empty", 32'(exp_grant.size()), 32'd0);
    check("sb_done_empty", 32'(exp_done.size()), 32'd0);
    check("sb_serial_empty", 32'(exp_ser.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
